// File: rtl/popcount_sched.sv
// popcount_sched
//   Front-end sequencer for the shared popcount engine. Two word sources feed
//   the engine's single input: the DMA AXI4-Stream and MMIO writes. Stream
//   bytes are masked by TKEEP, packet framing is tracked through TLAST, and a
//   COUNT_RST strobe clears the engine and aborts any open packet (the rest of
//   that packet is swallowed).
//
// Ports
//   S_AXIS_ACLK / S_AXIS_ARESETN   clock, synchronous active-low reset
//   S_AXIS_T*                      stream input (DATA, KEEP, LAST, VALID, READY)
//   WRITE_DATA / WRITE_VALID       MMIO word strobe into a one-entry buffer
//   COUNT_RST                      clear count, abort packet
//   ENG_DATA/VALID/READY           registered handshake into the engine
//   ENG_CLR                        one-cycle accumulator clear to the engine
//   ENG_BUSY / ENG_COUNT           engine status and running total
//   COUNT, COUNT_BUSY, PKT_DONE,
//   BEAT_CNT, MMIO_OVF             status towards the MMIO register block
module popcount_sched #(
  parameter int BEAT_W    = 16,
  parameter bit MMIO_PRIO = 1'b1
) (
  input  logic              S_AXIS_ACLK,
  input  logic              S_AXIS_ARESETN,
  input  logic [31:0]       S_AXIS_TDATA,
  input  logic [3:0]        S_AXIS_TKEEP,
  input  logic              S_AXIS_TLAST,
  input  logic              S_AXIS_TVALID,
  output logic              S_AXIS_TREADY,
  input  logic [31:0]       WRITE_DATA,
  input  logic              WRITE_VALID,
  input  logic              COUNT_RST,
  output logic [31:0]       ENG_DATA,
  output logic              ENG_VALID,
  input  logic              ENG_READY,
  output logic              ENG_CLR,
  input  logic              ENG_BUSY,
  input  logic [31:0]       ENG_COUNT,
  output logic [31:0]       COUNT,
  output logic              COUNT_BUSY,
  output logic              PKT_DONE,
  output logic [BEAT_W-1:0] BEAT_CNT,
  output logic              MMIO_OVF
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PKT   = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  function automatic logic [31:0] keep_mask(input logic [31:0] data,
                                            input logic [3:0]  keep);
    return data & {{8{keep[3]}}, {8{keep[2]}}, {8{keep[1]}}, {8{keep[0]}}};
  endfunction

  state_t            r_state;
  logic              r_mbuf_full;
  logic [31:0]       r_mbuf_data;
  logic              r_vld_p1;
  logic [31:0]       r_eng_data_p1;
  logic              r_rr_mmio;
  logic              r_clr;
  logic [31:0]       r_count;
  logic              r_pkt_done;
  logic [BEAT_W-1:0] r_beat_cnt;
  logic              r_ovf;

  logic w_out_free;
  logic w_flush;
  logic w_mmio_wins;
  logic w_tready;
  logic w_beat;
  logic w_fwd;
  logic w_mmio_go;

  // The engine register can take a new word when empty or handing off now.
  assign w_out_free  = !r_vld_p1 || ENG_READY;
  assign w_flush     = (r_state == ST_FLUSH);
  // Round-robin flag only matters when both sources compete.
  assign w_mmio_wins = r_mbuf_full && (MMIO_PRIO || !S_AXIS_TVALID || r_rr_mmio);
  // Flushed beats never reach the engine, so they need no free slot.
  assign w_tready    = S_AXIS_ARESETN && !COUNT_RST &&
                       (w_flush || (w_out_free && !w_mmio_wins));
  assign w_beat      = S_AXIS_TVALID && w_tready;
  assign w_fwd       = w_beat && !w_flush;
  assign w_mmio_go   = S_AXIS_ARESETN && !COUNT_RST && w_out_free && r_mbuf_full &&
                       (w_flush || w_mmio_wins);

  // Stage p0 -> p1: control, FSM and status
  always_ff @(posedge S_AXIS_ACLK) begin
    if (!S_AXIS_ARESETN) begin
      r_state     <= ST_IDLE;
      r_mbuf_full <= 1'b0;
      r_vld_p1    <= 1'b0;
      r_rr_mmio   <= 1'b1;
      r_clr       <= 1'b0;
      r_count     <= '0;
      r_pkt_done  <= 1'b0;
      r_beat_cnt  <= '0;
      r_ovf       <= 1'b0;
    end else begin
      r_clr   <= COUNT_RST;
      r_count <= ENG_COUNT;
      if (COUNT_RST) begin
        // Any unsent word and any buffered or coinciding MMIO write is lost.
        r_vld_p1    <= 1'b0;
        r_mbuf_full <= 1'b0;
        r_pkt_done  <= 1'b0;
        r_beat_cnt  <= '0;
        r_ovf       <= 1'b0;
        if (r_state == ST_PKT) r_state <= ST_FLUSH;
      end else begin
        if (w_mmio_go || w_fwd) r_vld_p1 <= 1'b1;
        else if (ENG_READY)     r_vld_p1 <= 1'b0;

        if (WRITE_VALID) begin
          if (!r_mbuf_full || w_mmio_go) r_mbuf_full <= 1'b1;
          else                           r_ovf       <= 1'b1;
        end else if (w_mmio_go) begin
          r_mbuf_full <= 1'b0;
        end

        if (w_mmio_go)  r_rr_mmio <= 1'b0;
        else if (w_fwd) r_rr_mmio <= 1'b1;

        if (w_fwd && !(&r_beat_cnt)) r_beat_cnt <= r_beat_cnt + 1'b1;

        if (w_beat) begin
          case (r_state)
            ST_IDLE: begin
              if (S_AXIS_TLAST) r_pkt_done <= 1'b1;
              else              r_state    <= ST_PKT;
            end
            ST_PKT: begin
              if (S_AXIS_TLAST) begin
                r_state    <= ST_IDLE;
                r_pkt_done <= 1'b1;
              end
            end
            ST_FLUSH: begin
              if (S_AXIS_TLAST) r_state <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
          endcase
        end
      end
    end
  end

  // Stage p0 -> p1: engine data register
  always_ff @(posedge S_AXIS_ACLK) begin
    if (!S_AXIS_ARESETN) begin
      r_eng_data_p1 <= '0;
    end else if (w_mmio_go) begin
      r_eng_data_p1 <= r_mbuf_data;
    end else if (w_fwd) begin
      r_eng_data_p1 <= keep_mask(S_AXIS_TDATA, S_AXIS_TKEEP);
    end
  end

  // MMIO buffer payload; occupancy is tracked by r_mbuf_full.
  always_ff @(posedge S_AXIS_ACLK) begin
    if (WRITE_VALID && (!r_mbuf_full || w_mmio_go)) r_mbuf_data <= WRITE_DATA;
  end

  assign S_AXIS_TREADY = w_tready;
  assign ENG_DATA      = r_eng_data_p1;
  assign ENG_VALID     = r_vld_p1;
  assign ENG_CLR       = r_clr;
  assign COUNT         = r_count;
  assign PKT_DONE      = r_pkt_done;
  assign BEAT_CNT      = r_beat_cnt;
  assign MMIO_OVF      = r_ovf;
  assign COUNT_BUSY    = (r_state != ST_IDLE) || r_mbuf_full || r_vld_p1 ||
                         ENG_BUSY || r_clr;

endmodule

// File: tb/tb_popcount_sched.sv
// Testbench for popcount_sched: directed stimulus, a packet/word-level model
// compared every cycle, a small engine responder, and literal expectations.
module tb_popcount_sched;
  localparam int BW  = 3;
  localparam int SAT = (1 << BW) - 1;

  logic          clk = 1'b0;
  logic          rstn;
  logic [31:0]   tdata;
  logic [3:0]    tkeep;
  logic          tlast, tvalid;
  logic          tready;
  logic [31:0]   wdata;
  logic          wvalid, crst;
  logic [31:0]   eng_data;
  logic          eng_valid, eng_ready, eng_clr, eng_busy;
  logic [31:0]   eng_count;
  logic [31:0]   count;
  logic          cbusy, pkt_done, ovf;
  logic [BW-1:0] beat_cnt;

  int n_pass  = 0;
  int n_total = 0;
  logic [31:0] log_q[$];

  always #5 clk = ~clk;

  popcount_sched #(.BEAT_W(BW), .MMIO_PRIO(1'b1)) dut (
    .S_AXIS_ACLK(clk), .S_AXIS_ARESETN(rstn),
    .S_AXIS_TDATA(tdata), .S_AXIS_TKEEP(tkeep), .S_AXIS_TLAST(tlast),
    .S_AXIS_TVALID(tvalid), .S_AXIS_TREADY(tready),
    .WRITE_DATA(wdata), .WRITE_VALID(wvalid), .COUNT_RST(crst),
    .ENG_DATA(eng_data), .ENG_VALID(eng_valid), .ENG_READY(eng_ready),
    .ENG_CLR(eng_clr), .ENG_BUSY(eng_busy), .ENG_COUNT(eng_count),
    .COUNT(count), .COUNT_BUSY(cbusy), .PKT_DONE(pkt_done),
    .BEAT_CNT(beat_cnt), .MMIO_OVF(ovf)
  );

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", nm, act, exp, $time);
  endfunction

  function automatic logic [31:0] keep_mask(input logic [31:0] d, input logic [3:0] k);
    logic [31:0] r;
    r = 32'h0;
    for (int b = 0; b < 4; b++) if (k[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  // Engine responder: counts ones of every accepted word, busy one cycle after.
  always @(posedge clk) begin
    if (!rstn) begin
      eng_count <= 32'h0;
      eng_busy  <= 1'b0;
    end else begin
      eng_busy <= eng_valid && eng_ready;
      if (eng_clr) eng_count <= 32'h0;
      else if (eng_valid && eng_ready) begin
        eng_count <= eng_count + 32'($countones(eng_data));
        log_q.push_back(eng_data);
      end
    end
  end

  // Model: one-word engine slot, one-word MMIO buffer, packet open/flushing flags.
  logic        m_init = 1'b0;
  logic        m_slot_v, m_buf_v, m_open, m_flush, m_done, m_ovf, m_clr;
  logic [31:0] m_slot_d, m_buf_d, m_count;
  int          m_beats;
  logic        m_trdy, mb_beat, mb_send;

  assign m_trdy  = rstn && !crst && (m_flush || ((!m_slot_v || eng_ready) && !m_buf_v));
  assign mb_beat = tvalid && m_trdy;
  assign mb_send = !crst && (!m_slot_v || eng_ready) && m_buf_v;

  always @(posedge clk) begin
    if (!rstn) begin
      m_init <= 1'b1; m_slot_v <= 1'b0; m_buf_v <= 1'b0; m_open <= 1'b0;
      m_flush <= 1'b0; m_done <= 1'b0; m_ovf <= 1'b0; m_clr <= 1'b0;
      m_slot_d <= 32'h0; m_buf_d <= 32'h0; m_count <= 32'h0; m_beats <= 0;
    end else begin
      m_clr   <= crst;
      m_count <= eng_count;
      if (crst) begin
        m_slot_v <= 1'b0; m_buf_v <= 1'b0; m_done <= 1'b0; m_beats <= 0; m_ovf <= 1'b0;
        if (m_open) begin m_flush <= 1'b1; m_open <= 1'b0; end
      end else begin
        if (mb_send) begin m_slot_v <= 1'b1; m_slot_d <= m_buf_d; end
        else if (mb_beat && !m_flush) begin m_slot_v <= 1'b1; m_slot_d <= keep_mask(tdata, tkeep); end
        else if (eng_ready) m_slot_v <= 1'b0;
        if (wvalid && (!m_buf_v || mb_send)) begin m_buf_v <= 1'b1; m_buf_d <= wdata; end
        else if (wvalid) m_ovf <= 1'b1;
        else if (mb_send) m_buf_v <= 1'b0;
        if (mb_beat && m_flush) begin
          if (tlast) m_flush <= 1'b0;
        end else if (mb_beat) begin
          if (m_beats < SAT) m_beats <= m_beats + 1;
          if (tlast) begin m_open <= 1'b0; m_done <= 1'b1; end
          else m_open <= 1'b1;
        end
      end
    end
  end

  // Compare process, mid-cycle when inputs and registers are settled.
  always @(negedge clk) begin
    if (m_init) begin
      chk("m_tready", 32'(tready), 32'(m_trdy));
      chk("m_eng_valid", 32'(eng_valid), 32'(m_slot_v));
      if (m_slot_v) chk("m_eng_data", eng_data, m_slot_d);
      chk("m_eng_clr", 32'(eng_clr), 32'(m_clr));
      chk("m_count", count, m_count);
      chk("m_pkt_done", 32'(pkt_done), 32'(m_done));
      chk("m_beat_cnt", 32'(beat_cnt), 32'(m_beats));
      chk("m_ovf", 32'(ovf), 32'(m_ovf));
      chk("m_busy", 32'(cbusy), 32'(m_open || m_flush || m_buf_v || m_slot_v || eng_busy || m_clr));
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic send_beat(input logic [31:0] d, input logic [3:0] k, input bit last, input bit fwd);
    bit got;
    got = 1'b0;
    tdata = d; tkeep = k; tlast = last; tvalid = 1'b1;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      if (tready) got = 1'b1;
      tick();
    end
    tvalid = 1'b0; tlast = 1'b0;
    chk("beat_accepted", 32'(got), 32'd1);
    if (got) begin
      if (fwd) begin
        chk("fwd_valid", 32'(eng_valid), 32'd1);
        chk("fwd_data", eng_data, keep_mask(d, k));
      end else begin
        chk("flush_no_valid", 32'(eng_valid), 32'd0);
      end
    end
  endtask

  task automatic pulse_rst();
    crst = 1'b1;
    tick();
    crst = 1'b0;
    chk("eng_clr_pulse", 32'(eng_clr), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1);
  end

  initial begin
    rstn = 1'b0; tvalid = 1'b1; tdata = 32'hFFFF_FFFF; tkeep = 4'hF; tlast = 1'b0;
    wvalid = 1'b0; wdata = 32'h0; crst = 1'b0; eng_ready = 1'b1;

    // T1 reset with TVALID high
    repeat (3) tick();
    chk("t1_tready", 32'(tready), 32'd0);
    chk("t1_eng_valid", 32'(eng_valid), 32'd0);
    chk("t1_eng_data", eng_data, 32'd0);
    chk("t1_eng_clr", 32'(eng_clr), 32'd0);
    chk("t1_count", count, 32'd0);
    chk("t1_busy", 32'(cbusy), 32'd0);
    chk("t1_done", 32'(pkt_done), 32'd0);
    chk("t1_beats", 32'(beat_cnt), 32'd0);
    chk("t1_ovf", 32'(ovf), 32'd0);
    tvalid = 1'b0; rstn = 1'b1;
    tick();

    // T2 four full beats
    for (int i = 0; i < 4; i++) send_beat(32'hFFFF_FFFF, 4'hF, i == 3, 1'b1);
    repeat (5) tick();
    chk("t2_count", count, 32'd128);
    chk("t2_beats", 32'(beat_cnt), 32'd4);
    chk("t2_done", 32'(pkt_done), 32'd1);
    chk("t2_busy", 32'(cbusy), 32'd0);

    // T3 TKEEP mask
    pulse_rst();
    chk("t3_beats_clr", 32'(beat_cnt), 32'd0);
    chk("t3_done_clr", 32'(pkt_done), 32'd0);
    send_beat(32'hFFFF_FFFF, 4'b0101, 1'b1, 1'b1);
    chk("t3_masked", eng_data, 32'h00FF_00FF);
    repeat (5) tick();
    chk("t3_count", count, 32'd16);

    // T4 MMIO priority and overflow
    pulse_rst();
    wvalid = 1'b1; wdata = 32'h0000_000F;
    tick();
    wvalid = 1'b0; tdata = 32'h3; tkeep = 4'hF; tlast = 1'b0; tvalid = 1'b1;
    @(negedge clk);
    chk("t4_tready_blocked", 32'(tready), 32'd0);
    tick();
    chk("t4_mmio_valid", 32'(eng_valid), 32'd1);
    chk("t4_mmio_first", eng_data, 32'h0000_000F);
    @(negedge clk);
    chk("t4_tready_after", 32'(tready), 32'd1);
    tick();
    tvalid = 1'b0;
    chk("t4_stream_second", eng_data, 32'h3);
    eng_ready = 1'b0; wvalid = 1'b1; wdata = 32'hAA;
    tick();
    wdata = 32'hBB;
    tick();
    wvalid = 1'b0;
    chk("t4_ovf", 32'(ovf), 32'd1);
    eng_ready = 1'b1;
    repeat (4) tick();
    chk("t4_count", count, 32'd10);
    chk("t4_ovf_sticky", 32'(ovf), 32'd1);
    send_beat(32'hDEAD_BEEF, 4'h0, 1'b1, 1'b1);
    chk("t4_zero_keep", eng_data, 32'h0);
    chk("t4_beats", 32'(beat_cnt), 32'd2);
    chk("t4_done", 32'(pkt_done), 32'd1);
    repeat (3) tick();

    // T5 reset mid-packet
    pulse_rst();
    send_beat(32'h1, 4'hF, 1'b0, 1'b1);
    send_beat(32'h3, 4'hF, 1'b0, 1'b1);
    pulse_rst();
    for (int i = 0; i < 3; i++) send_beat(32'hFFFF_FFFF, 4'hF, i == 2, 1'b0);
    repeat (5) tick();
    chk("t5_count", count, 32'd0);
    chk("t5_beats", 32'(beat_cnt), 32'd0);
    chk("t5_done", 32'(pkt_done), 32'd0);
    chk("t5_idle", 32'(cbusy), 32'd0);

    // T6 engine backpressure mid-packet
    pulse_rst();
    log_q.delete();
    send_beat(32'h0000_000F, 4'hF, 1'b0, 1'b1);
    eng_ready = 1'b0; tdata = 32'hFF; tkeep = 4'hF; tlast = 1'b0; tvalid = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("t6_tready", 32'(tready), 32'd0);
      chk("t6_hold_valid", 32'(eng_valid), 32'd1);
      chk("t6_hold_data", eng_data, 32'h0000_000F);
      tick();
    end
    eng_ready = 1'b1;
    send_beat(32'h0000_00FF, 4'hF, 1'b0, 1'b1);
    send_beat(32'hFFFF_0000, 4'hF, 1'b1, 1'b1);
    repeat (5) tick();
    chk("t6_count", count, 32'd28);
    chk("t6_beats", 32'(beat_cnt), 32'd3);
    chk("t6_words", 32'(log_q.size()), 32'd3);
    if (log_q.size() == 3) begin
      chk("t6_word0", log_q[0], 32'h0000_000F);
      chk("t6_word1", log_q[1], 32'h0000_00FF);
      chk("t6_word2", log_q[2], 32'hFFFF_0000);
    end

    // T7 beat counter saturation
    pulse_rst();
    for (int i = 0; i < 9; i++) send_beat(32'h1, 4'hF, i == 8, 1'b1);
    chk("t7_beats_sat", 32'(beat_cnt), 32'(SAT));
    chk("t7_done", 32'(pkt_done), 32'd1);
    repeat (4) tick();
    chk("t7_count", count, 32'd9);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
